// File: rtl/mapper_result_arbiter.sv
// ---------------------------------------------------------------------------
// mapper_result_arbiter
//
// Merges NUM_MAPPERS mapper result streams into a single stream heading to
// the reducer / PCIe return path. Arbitration is round-robin and
// packet-atomic: a granted mapper keeps the grant until the beat carrying
// its last flag is accepted. One registered output stage sits between the
// mappers and the downstream consumer. This is the output-side counterpart
// of the mapper distribution controller.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_map_valid   per-mapper beat valid
//   i_map_data    mapper m data at [m*DATA_W +: DATA_W]
//   i_map_last    per-mapper last beat of packet
//   o_map_rdy     per-mapper ready; only the granted bit can be 1
//   o_red_valid   registered output beat valid
//   o_red_data    registered output data
//   o_red_last    registered output last
//   i_red_rdy     downstream ready
//   o_active_src  currently / most recently granted mapper index
//   o_busy        1 while a packet transfer is in progress
//   o_pkt_count   packets whose last beat was accepted downstream (wraps)
// ---------------------------------------------------------------------------
module mapper_result_arbiter #(
    parameter int NUM_MAPPERS = 2,
    parameter int DATA_W      = 64,
    parameter int CNT_W       = 32
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_MAPPERS-1:0]           i_map_valid,
    input  logic [NUM_MAPPERS*DATA_W-1:0]    i_map_data,
    input  logic [NUM_MAPPERS-1:0]           i_map_last,
    output logic [NUM_MAPPERS-1:0]           o_map_rdy,
    output logic                             o_red_valid,
    output logic [DATA_W-1:0]                o_red_data,
    output logic                             o_red_last,
    input  logic                             i_red_rdy,
    output logic [$clog2(NUM_MAPPERS)-1:0]   o_active_src,
    output logic                             o_busy,
    output logic [CNT_W-1:0]                 o_pkt_count
);

    localparam int SRC_W = $clog2(NUM_MAPPERS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Round-robin search starting just after the previous winner. The
    // candidate index is wrapped by subtraction rather than by truncation so
    // that non-power-of-two mapper counts wrap exactly at NUM_MAPPERS-1.
    // Result is {found, index}.
    function automatic logic [SRC_W:0] rr_pick(
        input logic [NUM_MAPPERS-1:0] valid,
        input logic [SRC_W-1:0]       last
    );
        logic             found;
        logic [SRC_W-1:0] idx;
        logic [SRC_W-1:0] cand_idx;
        int               cand;
        found = 1'b0;
        idx   = {SRC_W{1'b0}};
        for (int i = 1; i <= NUM_MAPPERS; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_MAPPERS) begin
                cand = cand - NUM_MAPPERS;
            end else begin
                cand = cand;
            end
            cand_idx = SRC_W'(cand);
            if (!found && valid[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    state_t              state_q,      state_d;
    logic [SRC_W-1:0]    grant_q,      grant_d;
    logic [SRC_W-1:0]    last_grant_q, last_grant_d;
    logic                red_valid_q,  red_valid_d;
    logic [DATA_W-1:0]   red_data_q,   red_data_d;
    logic                red_last_q,   red_last_d;
    logic [CNT_W-1:0]    pkt_count_q,  pkt_count_d;

    logic [SRC_W:0]          pick;
    logic                    pick_found;
    logic [SRC_W-1:0]        pick_idx;
    logic                    grant_rdy;
    logic                    beat_accept;
    logic [DATA_W-1:0]       sel_data;
    logic                    sel_last;
    logic [NUM_MAPPERS-1:0]  map_rdy;

    // Arbitration, grant handshake, output-stage and counter next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        red_valid_d  = red_valid_q;
        red_data_d   = red_data_q;
        red_last_d   = red_last_q;
        pkt_count_d  = pkt_count_q;
        map_rdy      = {NUM_MAPPERS{1'b0}};
        beat_accept  = 1'b0;

        pick       = rr_pick(i_map_valid, last_grant_q);
        pick_found = pick[SRC_W];
        pick_idx   = pick[SRC_W-1:0];

        // The output register can take a new beat when it is empty or is
        // being drained this cycle.
        grant_rdy = ~red_valid_q | i_red_rdy;
        sel_data  = i_map_data[int'(grant_q)*DATA_W +: DATA_W];
        sel_last  = i_map_last[grant_q];

        case (state_q)
            ST_IDLE: begin
                // One arbitration cycle; no beat is taken while idle.
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                map_rdy[grant_q] = grant_rdy;
                beat_accept      = i_map_valid[grant_q] & grant_rdy;
                // Grant is held across valid gaps; it is released only on
                // the accepted last beat.
                if (beat_accept && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (beat_accept) begin
            red_valid_d = 1'b1;
            red_data_d  = sel_data;
            red_last_d  = sel_last;
        end else if (i_red_rdy) begin
            red_valid_d = 1'b0;
        end else begin
            red_valid_d = red_valid_q;
        end

        if (red_valid_q && i_red_rdy && red_last_q) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // State, grant, output stage and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= {SRC_W{1'b0}};
            // Start the pointer at the top index so mapper 0 wins first.
            last_grant_q <= SRC_W'(NUM_MAPPERS - 1);
            red_valid_q  <= 1'b0;
            red_data_q   <= {DATA_W{1'b0}};
            red_last_q   <= 1'b0;
            pkt_count_q  <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            red_valid_q  <= red_valid_d;
            red_data_q   <= red_data_d;
            red_last_q   <= red_last_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign o_map_rdy    = map_rdy;
    assign o_red_valid  = red_valid_q;
    assign o_red_data   = red_data_q;
    assign o_red_last   = red_last_q;
    assign o_active_src = grant_q;
    assign o_busy       = (state_q == ST_XFER);
    assign o_pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_mapper_result_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mapper_result_arbiter (3 mappers, 16-bit data, 4-bit counter).
// Beat data encodes {mapper[3:0], packet[7:0], beat[3:0]}.
// ---------------------------------------------------------------------------
module tb_mapper_result_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              i_rst;
    logic [N-1:0]      map_valid;
    logic [N*DW-1:0]   map_data;
    logic [N-1:0]      map_last;
    logic [N-1:0]      o_map_rdy;
    logic              o_red_valid;
    logic [DW-1:0]     o_red_data;
    logic              o_red_last;
    logic              red_rdy;
    logic [1:0]        o_active_src;
    logic              o_busy;
    logic [CW-1:0]     o_pkt_count;

    logic [DW:0] drvq [N][$];
    logic [DW:0] expq [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mapper_result_arbiter #(
        .NUM_MAPPERS(N),
        .DATA_W     (DW),
        .CNT_W      (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_map_valid (map_valid),
        .i_map_data  (map_data),
        .i_map_last  (map_last),
        .o_map_rdy   (o_map_rdy),
        .o_red_valid (o_red_valid),
        .o_red_data  (o_red_data),
        .o_red_last  (o_red_last),
        .i_red_rdy   (red_rdy),
        .o_active_src(o_active_src),
        .o_busy      (o_busy),
        .o_pkt_count (o_pkt_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int m, input int p, input int b);
        return {4'(m), 8'(p), 4'(b)};
    endfunction

    task automatic load_pkt(input int m, input int p, input int nb);
        for (int b = 0; b < nb; b++) drvq[m].push_back({mk(m, p, b), (b == nb - 1)});
    endtask

    task automatic expect_pkt(input int m, input int p, input int nb);
        for (int b = 0; b < nb; b++) expq.push_back({mk(m, p, b), (b == nb - 1)});
    endtask

    task automatic wait_done(input string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (expq.size() == 0 && drvq[0].size() == 0 && drvq[1].size() == 0 &&
                drvq[2].size() == 0 && !o_busy && !o_red_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=pending required=drained", name);
    endtask

    task automatic wait_busy(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_busy) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=idle required=busy", name);
    endtask

    task automatic wait_valid(input string name);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (o_red_valid) return;
        end
        checks++;
        failures++;
        $display("FAIL %s_timeout actual=novalid required=valid", name);
    endtask

    task automatic do_reset;
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(o_red_valid),  32'd0);
        check({tag, "_data"},   32'(o_red_data),   32'd0);
        check({tag, "_last"},   32'(o_red_last),   32'd0);
        check({tag, "_rdy"},    32'(o_map_rdy),    32'd0);
        check({tag, "_src"},    32'(o_active_src), 32'd0);
        check({tag, "_busy"},   32'(o_busy),       32'd0);
        check({tag, "_count"},  32'(o_pkt_count),  32'd0);
    endtask

    // Mapper-side driver: a beat is retired when valid&ready was seen
    // before the clock edge.
    initial begin
        logic [N-1:0] acc;
        map_valid = '0;
        map_data  = '0;
        map_last  = '0;
        forever begin
            @(negedge clk);
            acc = map_valid & o_map_rdy;
            @(posedge clk);
            #1;
            for (int m = 0; m < N; m++) begin
                if (acc[m] && drvq[m].size() > 0) void'(drvq[m].pop_front());
                if (drvq[m].size() > 0) begin
                    map_valid[m]           = 1'b1;
                    map_data[m*DW +: DW]   = drvq[m][0][DW:1];
                    map_last[m]            = drvq[m][0][0];
                end else begin
                    map_valid[m] = 1'b0;
                    map_last[m]  = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted output beat is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (o_red_valid && red_rdy) begin
                logic [DW:0] e;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", o_red_data);
                end else begin
                    e = expq.pop_front();
                    check("beat_data", 32'(o_red_data), 32'(e[DW:1]));
                    check("beat_last", 32'(o_red_last), 32'(e[0]));
                end
            end
        end
    end

    initial begin
        i_rst   = 1'b1;
        red_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        i_rst = 1'b0;

        // Three-beat packet from mapper 0, downstream always ready.
        @(negedge clk);
        load_pkt(0, 1, 3);
        expect_pkt(0, 1, 3);
        wait_done("t1");
        check("t1_count", 32'(o_pkt_count), 32'd1);

        // Two mappers competing with back-to-back 2-beat packets.
        do_reset;
        load_pkt(0, 2, 2);
        load_pkt(0, 3, 2);
        load_pkt(1, 4, 2);
        load_pkt(1, 5, 2);
        expect_pkt(0, 2, 2);
        expect_pkt(1, 4, 2);
        expect_pkt(0, 3, 2);
        expect_pkt(1, 5, 2);
        wait_done("t2");
        check("t2_count", 32'(o_pkt_count), 32'd4);

        // Downstream stall for 4 cycles with beat 1 held in the output stage.
        load_pkt(0, 6, 4);
        expect_pkt(0, 6, 4);
        wait_valid("t3");
        @(posedge clk);
        #1;
        red_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_hold_data",  32'(o_red_data),  32'(mk(0, 6, 1)));
            check("t3_hold_valid", 32'(o_red_valid), 32'd1);
            check("t3_rdy_low",    32'(o_map_rdy),   32'd0);
        end
        @(posedge clk);
        #1;
        red_rdy = 1'b1;
        wait_done("t3");
        check("t3_count", 32'(o_pkt_count), 32'd5);

        // Round-robin wrap with three mappers.
        do_reset;
        load_pkt(1, 7, 2);
        expect_pkt(1, 7, 2);
        wait_busy("t4a");
        check("t4_src_m1", 32'(o_active_src), 32'd1);
        wait_done("t4a");
        load_pkt(0, 8, 2);
        load_pkt(2, 9, 2);
        expect_pkt(2, 9, 2);
        expect_pkt(0, 8, 2);
        wait_busy("t4b");
        check("t4_src_m2", 32'(o_active_src), 32'd2);
        wait_done("t4b");
        check("t4_src_last", 32'(o_active_src), 32'd0);

        // Reset in the middle of a 4-beat packet.
        load_pkt(0, 10, 4);
        expq.push_back({mk(0, 10, 0), 1'b0});
        wait_valid("t5");
        i_rst = 1'b1;
        drvq[0].delete();
        @(negedge clk);
        check_all_zero("t5_rst");
        i_rst = 1'b0;
        load_pkt(0, 11, 3);
        expect_pkt(0, 11, 3);
        wait_done("t5");
        check("t5_count", 32'(o_pkt_count), 32'd1);

        // Packet counter wrap at 16 with single-beat packets.
        do_reset;
        for (int p = 0; p < 15; p++) begin
            load_pkt(0, 20 + p, 1);
            expect_pkt(0, 20 + p, 1);
        end
        wait_done("t6a");
        check("t6_count15", 32'(o_pkt_count), 32'd15);
        load_pkt(0, 40, 1);
        expect_pkt(0, 40, 1);
        wait_done("t6b");
        check("t6_count_wrap", 32'(o_pkt_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
